// File: rtl/pipelined_carry_adder_pkg.sv
// Shared defaults and helpers for the pipelined ripple-carry adder.
// Also provides the elaboration-time check that WIDTH splits evenly into SEG-bit segments.
package pipelined_carry_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG   = 8;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

`ifndef PIPELINED_CARRY_ADDER_CHECK_SEG
`define PIPELINED_CARRY_ADDER_CHECK_SEG(W, S) \
  if (((W) % (S)) != 0) begin : g_seg_check \
    $error("pipelined_carry_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", (W), (S)); \
  end
`endif

// File: rtl/pipelined_carry_adder_rca_segment.sv
// Combinational SEG-bit ripple chain of full adders.
// One pipeline stage contains one segment.
module rca_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  always_comb begin
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder: one SEG-bit segment per register stage, valid/ready at both ends.
// Defining PIPELINED_CARRY_ADDER_SUB_EN adds a 'sub' port that computes a + ~b + 1 instead.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  `PIPELINED_CARRY_ADDER_CHECK_SEG(WIDTH, SEG)

  logic             sub_in;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  logic [STAGES-1:0] v, load, up_v;
  logic [WIDTH-1:0]  psum [STAGES];
  logic [WIDTH-1:0]  nxt_psum [STAGES];
  logic [WIDTH-1:0]  rem_a [STAGES];
  logic [WIDTH-1:0]  rem_b [STAGES];
  logic [WIDTH-1:0]  nxt_rem_a [STAGES];
  logic [WIDTH-1:0]  nxt_rem_b [STAGES];
  logic              carry [STAGES];
  logic              nxt_carry [STAGES];
  logic              sub_r [STAGES];
  logic              nxt_sub [STAGES];

  // rem_a/rem_b keep the not-yet-added operand bits right-aligned, so every stage reads slice [SEG-1:0].
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] seg_a, seg_b, seg_s;
    logic           seg_ci, seg_co, seg_sub;

    if (k == 0) begin : g_head
      assign seg_sub      = sub_in;
      assign seg_a        = a[SEG-1:0];
      assign seg_b        = b[SEG-1:0];
      assign seg_ci       = sub_in | cin;
      assign up_v[k]      = in_valid;
      assign nxt_rem_a[k] = a >> SEG;
      assign nxt_rem_b[k] = b >> SEG;
      assign nxt_psum[k]  = WIDTH'(seg_s);
    end else begin : g_tail
      assign seg_sub      = sub_r[k-1];
      assign seg_a        = rem_a[k-1][SEG-1:0];
      assign seg_b        = rem_b[k-1][SEG-1:0];
      assign seg_ci       = carry[k-1];
      assign up_v[k]      = v[k-1];
      assign nxt_rem_a[k] = rem_a[k-1] >> SEG;
      assign nxt_rem_b[k] = rem_b[k-1] >> SEG;
      assign nxt_psum[k]  = psum[k-1] | (WIDTH'(seg_s) << (k * SEG));
    end

    assign nxt_carry[k] = seg_co;
    assign nxt_sub[k]   = seg_sub;

    rca_segment #(.SEG(SEG)) u_seg (
      .a  (seg_a),
      .b  (seg_b ^ {SEG{seg_sub}}),
      .ci (seg_ci),
      .s  (seg_s),
      .co (seg_co)
    );
  end

  // Ready ripples backwards: a stage may load when empty or when its contents move on this cycle.
  always_comb begin
    logic down;
    down = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~v[k] | down;
      down    = load[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        psum[k]  <= '0;
        rem_a[k] <= '0;
        rem_b[k] <= '0;
        carry[k] <= 1'b0;
        sub_r[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v[k]     <= up_v[k];
          psum[k]  <= nxt_psum[k];
          rem_a[k] <= nxt_rem_a[k];
          rem_b[k] <= nxt_rem_b[k];
          carry[k] <= nxt_carry[k];
          sub_r[k] <= nxt_sub[k];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[STAGES-1];
  assign sum       = psum[STAGES-1];
  assign cout      = carry[STAGES-1];

endmodule
